// File: rtl/alu_comparator_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_comparator_pipe_pkg
// Description : Shared operation encoding and result helpers for the
//               pipelined branch comparator.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_comparator_pipe_pkg;

    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_EQ   = 3'd1,
        C_NE   = 3'd2,
        C_LT   = 3'd3,
        C_GE   = 3'd4,
        C_LTU  = 3'd5,
        C_GEU  = 3'd6
    } ComparatorOp;

    // Four-character ASCII mnemonic, kept as a packed vector so it stays synthesizable.
    function automatic logic [31:0] op_name(input ComparatorOp op);
        logic [31:0] r_name;
        r_name = "????";
        case (op)
            C_NONE: r_name = "NONE";
            C_EQ:   r_name = "EQ  ";
            C_NE:   r_name = "NE  ";
            C_LT:   r_name = "LT  ";
            C_GE:   r_name = "GE  ";
            C_LTU:  r_name = "LTU ";
            C_GEU:  r_name = "GEU ";
            default: r_name = "????";
        endcase
        return r_name;
    endfunction

    function automatic logic is_signed_op(input ComparatorOp op);
        return (op == C_LT) || (op == C_GE);
    endfunction

    function automatic logic final_result(input ComparatorOp op, input logic eq, input logic lt);
        logic r_res;
        r_res = 1'b0;
        case (op)
            C_EQ:         r_res = eq;
            C_NE:         r_res = !eq;
            C_LT, C_LTU:  r_res = !eq && lt;
            C_GE, C_GEU:  r_res = eq || !lt;
            default:      r_res = 1'b0;
        endcase
        return r_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comparator_pipe_chunk_stage.sv
`default_nettype none
// ============================================================================
// Module      : cmp_chunk_stage
// Description : Compares the top chunk of the remaining operand bits, folds it
//               into the running eq/lt flags and registers the result.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_chunk_stage
    import alu_comparator_pipe_pkg::*;
#(
    parameter int CW           = 8,
    parameter int REM_W        = 32,
    parameter bit SIGNED_CHUNK = 1'b0,
    parameter int TAG_WIDTH    = 4,
    localparam int c_OUT_W     = (REM_W > CW) ? (REM_W - CW) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  ComparatorOp          i_op,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic                 i_eq,
    input  logic                 i_lt,
    input  logic [REM_W-1:0]     i_a,
    input  logic [REM_W-1:0]     i_b,
    input  logic                 i_down_ready,
    output logic                 o_valid,
    output ComparatorOp          o_op,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic                 o_eq,
    output logic                 o_lt,
    output logic [c_OUT_W-1:0]   o_a,
    output logic [c_OUT_W-1:0]   o_b
);

    logic [CW-1:0]        w_chunk_a;
    logic [CW-1:0]        w_chunk_b;
    logic                 w_chunk_lt;
    logic                 w_eq_d;
    logic                 w_lt_d;
    logic                 w_ready;
    logic                 w_load;
    logic [c_OUT_W-1:0]   w_rest_a;
    logic [c_OUT_W-1:0]   w_rest_b;

    logic                 r_valid;
    ComparatorOp          r_op;
    logic [TAG_WIDTH-1:0] r_tag;
    logic                 r_eq;
    logic                 r_lt;
    logic [c_OUT_W-1:0]   r_a;
    logic [c_OUT_W-1:0]   r_b;

    assign w_chunk_a = i_a[REM_W-1 -: CW];
    assign w_chunk_b = i_b[REM_W-1 -: CW];

    // Only the MSB chunk of a signed op carries the sign bit.
    always_comb begin
        if (SIGNED_CHUNK && is_signed_op(i_op)) begin
            w_chunk_lt = $signed(w_chunk_a) < $signed(w_chunk_b);
        end else begin
            w_chunk_lt = w_chunk_a < w_chunk_b;
        end
    end

    assign w_eq_d = i_eq && (w_chunk_a == w_chunk_b);
    assign w_lt_d = (i_eq && (w_chunk_a != w_chunk_b)) ? w_chunk_lt : i_lt;

    if (REM_W > CW) begin : g_rest
        assign w_rest_a = i_a[REM_W-CW-1:0];
        assign w_rest_b = i_b[REM_W-CW-1:0];
    end else begin : g_no_rest
        assign w_rest_a = '0;
        assign w_rest_b = '0;
    end

    assign w_ready = !r_valid || i_down_ready;
    assign w_load  = w_ready && i_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_op    <= C_NONE;
            r_tag   <= '0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (w_ready) begin
                r_valid <= i_valid;
            end
            if (w_load) begin
                r_op  <= i_op;
                r_tag <= i_tag;
                r_eq  <= w_eq_d;
                r_lt  <= w_lt_d;
                r_a   <= w_rest_a;
                r_b   <= w_rest_b;
            end
        end
    end

    assign o_ready = w_ready;
    assign o_valid = r_valid;
    assign o_op    = r_op;
    assign o_tag   = r_tag;
    assign o_eq    = r_eq;
    assign o_lt    = r_lt;
    assign o_a     = r_a;
    assign o_b     = r_b;

endmodule
`default_nettype wire

// File: rtl/alu_comparator_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_comparator_pipe
// Description : Elastic, chunked branch comparator resolving MSB chunk first,
//               one chunk per stage, with tag passthrough and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comparator_pipe
    import alu_comparator_pipe_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 4,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  ComparatorOp          in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_result,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int c_CW = WIDTH / STAGES;

    logic [STAGES-1:0]    w_valid;
    logic [STAGES-1:0]    w_ready;
    logic [STAGES-1:0]    w_eq;
    logic [STAGES-1:0]    w_lt;
    ComparatorOp          w_op  [STAGES];
    logic [TAG_WIDTH-1:0] w_tag [STAGES];
    logic                 w_unused_tail;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_REM_W = WIDTH - k * c_CW;
        localparam int c_OUT_W = (c_REM_W > c_CW) ? (c_REM_W - c_CW) : 1;

        logic                 w_in_valid;
        ComparatorOp          w_in_op;
        logic [TAG_WIDTH-1:0] w_in_tag;
        logic                 w_in_eq;
        logic                 w_in_lt;
        logic [c_REM_W-1:0]   w_in_a;
        logic [c_REM_W-1:0]   w_in_b;
        logic                 w_down_ready;
        logic [c_OUT_W-1:0]   w_rem_a;
        logic [c_OUT_W-1:0]   w_rem_b;

        if (k == 0) begin : g_head
            assign w_in_valid = in_valid && !flush;
            assign w_in_op    = in_op;
            assign w_in_tag   = in_tag;
            assign w_in_eq    = 1'b1;
            assign w_in_lt    = 1'b0;
            assign w_in_a     = in_a;
            assign w_in_b     = in_b;
        end else begin : g_link
            assign w_in_valid = w_valid[k-1];
            assign w_in_op    = w_op[k-1];
            assign w_in_tag   = w_tag[k-1];
            assign w_in_eq    = w_eq[k-1];
            assign w_in_lt    = w_lt[k-1];
            assign w_in_a     = g_stage[k-1].w_rem_a;
            assign w_in_b     = g_stage[k-1].w_rem_b;
        end

        if (k == STAGES - 1) begin : g_tail
            assign w_down_ready = out_ready;
        end else begin : g_mid
            assign w_down_ready = w_ready[k+1];
        end

        cmp_chunk_stage #(
            .CW           (c_CW),
            .REM_W        (c_REM_W),
            .SIGNED_CHUNK (k == 0),
            .TAG_WIDTH    (TAG_WIDTH)
        ) u_stage (
            .clk          (clk),
            .rst          (reset),
            .i_flush      (flush),
            .i_valid      (w_in_valid),
            .o_ready      (w_ready[k]),
            .i_op         (w_in_op),
            .i_tag        (w_in_tag),
            .i_eq         (w_in_eq),
            .i_lt         (w_in_lt),
            .i_a          (w_in_a),
            .i_b          (w_in_b),
            .i_down_ready (w_down_ready),
            .o_valid      (w_valid[k]),
            .o_op         (w_op[k]),
            .o_tag        (w_tag[k]),
            .o_eq         (w_eq[k]),
            .o_lt         (w_lt[k]),
            .o_a          (w_rem_a),
            .o_b          (w_rem_b)
        );
    end

    // The last stage has no operand bits left; its padding is intentionally dropped.
    assign w_unused_tail = ^{g_stage[STAGES-1].w_rem_a, g_stage[STAGES-1].w_rem_b};

    // A request presented during flush is dropped rather than accepted.
    assign in_ready   = w_ready[0] && !flush;
    assign out_valid  = w_valid[STAGES-1];
    assign out_result = final_result(w_op[STAGES-1], w_eq[STAGES-1], w_lt[STAGES-1]);
    assign out_tag    = w_tag[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_alu_comparator_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_comparator_pipe
// Description : Scoreboard bench for alu_comparator_pipe at STAGES = 4, 1, 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_comparator_pipe;
    import alu_comparator_pipe_pkg::*;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int ND = 3;

    typedef struct {
        int          dut;
        ComparatorOp op;
        logic [31:0] a;
        logic [31:0] b;
        logic        res;
        logic [3:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              flush;
    logic              in_valid     [ND];
    logic              out_ready    [ND];
    ComparatorOp       in_op;
    logic [W-1:0]      in_a;
    logic [W-1:0]      in_b;
    logic [TW-1:0]     in_tag;
    logic              in_ready_w   [ND];
    logic              out_valid_w  [ND];
    logic              out_result_w [ND];
    logic [TW-1:0]     out_tag_w    [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int c_ST = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
        alu_comparator_pipe #(
            .WIDTH     (W),
            .STAGES    (c_ST),
            .TAG_WIDTH (TW)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready_w[g]),
            .in_op      (in_op),
            .in_a       (in_a),
            .in_b       (in_b),
            .in_tag     (in_tag),
            .out_valid  (out_valid_w[g]),
            .out_ready  (out_ready[g]),
            .out_result (out_result_w[g]),
            .out_tag    (out_tag_w[g])
        );
    end

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int stages_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 2);
    endfunction

    function automatic logic ref_cmp(input ComparatorOp op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            C_EQ:    return a == b;
            C_NE:    return a != b;
            C_LT:    return $signed(a) < $signed(b);
            C_GE:    return $signed(a) >= $signed(b);
            C_LTU:   return a < b;
            C_GEU:   return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: pops the oldest expectation of a DUT on every output transfer.
    bit         stall_q [ND];
    logic [4:0] held_q  [ND];
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            int   idx;
            exp_t e;
            if (stall_q[d]) begin
                chk($sformatf("stall_hold[%0d]", d), 32'({out_result_w[d], out_tag_w[d]}), 32'(held_q[d]));
            end
            stall_q[d] = !reset && !flush && out_valid_w[d] && !out_ready[d];
            held_q[d]  = {out_result_w[d], out_tag_w[d]};
            if (!reset && out_valid_w[d] && out_ready[d]) begin
                idx = -1;
                foreach (sb[i]) if (idx < 0 && sb[i].dut == d) idx = i;
                if (idx < 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out[%0d]: actual=tag %0h required=no output", d, out_tag_w[d]);
                end else begin
                    e = sb[idx];
                    sb.delete(idx);
                    chk($sformatf("result[%0d] %s a=%0h b=%0h", d, op_name(e.op), e.a, e.b),
                        32'(out_result_w[d]), 32'(e.res));
                    chk($sformatf("tag[%0d]", d), 32'(out_tag_w[d]), 32'(e.tag));
                    if (e.lat) chk($sformatf("latency[%0d]", d), 32'(cyc - e.acc), 32'(stages_of(d)));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int d, input ComparatorOp op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input bit lat, input bit rnd_bp);
        exp_t e;
        bit   ok;
        ok     = 1'b0;
        in_op  = op;
        in_a   = a;
        in_b   = b;
        in_tag = tag;
        in_valid[d] = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (rnd_bp) out_ready[d] = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = in_ready_w[d];
            @(posedge clk);
            if (ok) begin
                e.dut = d; e.op = op; e.a = a; e.b = b;
                e.res = ref_cmp(op, a, b); e.tag = tag; e.acc = cyc; e.lat = lat;
                sb.push_back(e);
            end
            #1;
        end
        in_valid[d] = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout[%0d]: actual=not accepted required=accepted", d);
        end
    endtask

    task automatic rand_send(input int d, input logic [3:0] tag, input bit lat, input bit rnd_bp);
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        case ($urandom_range(0, 2))
            0:       b = a;
            1:       b = a ^ (32'h1 << $urandom_range(0, 31));
            default: b = $urandom;
        endcase
        send(d, ComparatorOp'(3'($urandom_range(0, 6))), a, b, tag, lat, rnd_bp);
    endtask

    task automatic run_directed(input int d);
        ComparatorOp ops[9] = '{C_EQ, C_NE, C_LT, C_LT, C_LTU, C_GEU, C_LTU, C_GE, C_NONE};
        logic [31:0] as[9]  = '{32'd10, 32'd10, 32'hFFFF_FFF9, 32'd10, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'h1234_5600, 32'h1234_5600, 32'd5};
        logic [31:0] bs[9]  = '{32'd10, 32'd9, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd0,
                                32'd0, 32'h1234_5601, 32'h1234_5601, 32'd5};
        for (int i = 0; i < 9; i++) send(d, ops[i], as[i], bs[i], i[3:0], 1'b1, 1'b0);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: actual=%0d outstanding required=0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        flush  = 1'b0;
        in_op  = C_NONE;
        in_a   = '0;
        in_b   = '0;
        in_tag = '0;
        for (int d = 0; d < ND; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_out_valid[%0d]", d), 32'(out_valid_w[d]), 32'd0);
            chk($sformatf("rst_out_result[%0d]", d), 32'(out_result_w[d]), 32'd0);
            chk($sformatf("rst_out_tag[%0d]", d), 32'(out_tag_w[d]), 32'd0);
            chk($sformatf("rst_in_ready[%0d]", d), 32'(in_ready_w[d]), 32'd1);
        end
        @(posedge clk);
        #1;

        run_directed(0);
        drain();

        for (int i = 0; i < 40; i++) rand_send(0, i[3:0], 1'b0, 1'b1);
        out_ready[0] = 1'b1;
        drain();

        // Stall the output: four entries fill the pipe, then the rest wait.
        out_ready[0] = 1'b0;
        for (int t = 0; t < 4; t++) rand_send(0, t[3:0], 1'b0, 1'b0);
        @(negedge clk);
        chk("in_ready_full", 32'(in_ready_w[0]), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("in_ready_still_full", 32'(in_ready_w[0]), 32'd0);
        chk("out_valid_stalled", 32'(out_valid_w[0]), 32'd1);
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
        for (int t = 4; t < 8; t++) rand_send(0, t[3:0], 1'b0, 1'b0);
        drain();

        // Flush with three in flight and a request offered in the flush cycle.
        for (int t = 0; t < 3; t++) send(0, C_EQ, 32'(t), 32'(t), t[3:0], 1'b0, 1'b0);
        flush       = 1'b1;
        in_valid[0] = 1'b1;
        in_op       = C_EQ;
        in_tag      = 4'd3;
        @(negedge clk);
        chk("in_ready_flush", 32'(in_ready_w[0]), 32'd0);
        @(posedge clk);
        sb.delete();
        #1;
        flush       = 1'b0;
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("out_valid_after_flush", 32'(out_valid_w[0]), 32'd0);
        repeat (8) @(posedge clk);
        #1;

        // Reset with the pipe full.
        for (int t = 0; t < 4; t++) rand_send(0, t[3:0], 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        sb.delete();
        #1 reset = 1'b0;
        @(negedge clk);
        chk("out_valid_after_reset", 32'(out_valid_w[0]), 32'd0);
        @(posedge clk);
        #1;
        send(0, C_EQ, 32'd5, 32'd5, 4'd9, 1'b1, 1'b0);
        send(0, C_NONE, 32'd7, 32'd7, 4'd10, 1'b1, 1'b0);
        drain();

        for (int d = 1; d < ND; d++) begin
            run_directed(d);
            for (int i = 0; i < 10; i++) rand_send(d, i[3:0], 1'b1, 1'b0);
            drain();
        end

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
